// File: rtl/water_tank_pkg.sv
// Shared definitions for the water tank level monitor: level state encoding
// and the default sensor thresholds.
package water_tank_pkg;

  typedef enum logic [1:0] {
    LVL_NORMAL   = 2'b00,
    LVL_FULL     = 2'b01,
    LVL_CRITICAL = 2'b10
  } lvl_state_e;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_FULL_LEVEL     = 200;
  localparam int DEF_CRITICAL_LEVEL = 40;
  localparam int DEF_HYST           = 8;
  localparam int DEF_DEBOUNCE       = 4;
  localparam int DEF_TIMEOUT        = 1000;

endpackage

// File: rtl/tank_level_monitor_if.sv
// Sensor-sample / level-flag bundle between the level sensor front end
// (master) and the tank level monitor (slave).
interface tank_level_monitor_if #(
  parameter int WIDTH = 8
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample_level;
  logic             full_tank;
  logic             critical_level;
  logic [WIDTH-1:0] level_out;
  logic             sensor_fault;

  modport master (
    output sample_valid, sample_level,
    input  full_tank, critical_level, level_out, sensor_fault
  );

  modport slave (
    input  sample_valid, sample_level,
    output full_tank, critical_level, level_out, sensor_fault
  );
endinterface

// File: rtl/level_debouncer.sv
// Consecutive-qualifier counter. Counts valid qualifying samples, holds on
// idle cycles, clears on a valid non-qualifying sample, and raises hit on the
// sample that brings the count to DEBOUNCE. A hit always moves the owning FSM,
// so the count clears itself on hit. restart reloads the count at 1.
module level_debouncer #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic valid,
  input  logic qualify,
  input  logic restart,
  output logic hit
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = DEBOUNCE[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // Next count and hit detection.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    cnt_d   = cnt_q;
    cnt_inc = restart ? CW'(1) : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1));
    hit     = valid && qualify && (cnt_inc == CNT_MAX);
    if (clear || hit) begin
      cnt_d = '0;
    end else if (valid) begin
      cnt_d = qualify ? cnt_inc : '0;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    // NOTE: state is written with <= so every flop samples pre-edge values regardless of block order.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tank_level_monitor.sv
// Tank level monitor: debounces raw level samples with hysteresis into the
// full_tank / critical_level flags feeding the water tank FSM.
// Optional sensor watchdog enabled by defining SENSOR_TIMEOUT_EN; without it
// sensor_fault is tied 0 and TIMEOUT is only range-checked.
module tank_level_monitor
  import water_tank_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int FULL_LEVEL     = DEF_FULL_LEVEL,
  parameter int CRITICAL_LEVEL = DEF_CRITICAL_LEVEL,
  parameter int HYST           = DEF_HYST,
  parameter int DEBOUNCE       = DEF_DEBOUNCE,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  tank_level_monitor_if.slave   bus
);
  if (!(CRITICAL_LEVEL + HYST < FULL_LEVEL - HYST)) begin : g_bad_thresholds
    $error("tank_level_monitor: CRITICAL_LEVEL+HYST must be below FULL_LEVEL-HYST");
  end
  if (DEBOUNCE < 1 || TIMEOUT < 1) begin : g_bad_counts
    $error("tank_level_monitor: DEBOUNCE and TIMEOUT must be at least 1");
  end

  // Thresholds held one bit wider than the sample so sums/differences never wrap.
  localparam int FULL_EXIT_I = FULL_LEVEL - HYST;
  localparam int CRIT_EXIT_I = CRITICAL_LEVEL + HYST;
  localparam logic [WIDTH:0] FULL_ENTER = FULL_LEVEL[WIDTH:0];
  localparam logic [WIDTH:0] CRIT_ENTER = CRITICAL_LEVEL[WIDTH:0];
  localparam logic [WIDTH:0] FULL_EXIT  = FULL_EXIT_I[WIDTH:0];
  localparam logic [WIDTH:0] CRIT_EXIT  = CRIT_EXIT_I[WIDTH:0];

  lvl_state_e       state_q, state_d;
  logic             dir_q, dir_d;      // last NORMAL-state qualifier: 1 = full side
  logic             full_q, crit_q;
  logic [WIDTH-1:0] level_q;
  logic             qualify, restart, hit, timeout;
  logic [WIDTH:0]   sample_x;

  assign sample_x = {1'b0, bus.sample_level};

  wire above_full = sample_x >= FULL_ENTER;
  wire below_crit = sample_x <= CRIT_ENTER;

`ifdef SENSOR_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX = TIMEOUT[WW-1:0];

  logic [WW-1:0] wd_q, wd_d;
  logic          fault_q, fault_d;

  // Watchdog: idle-cycle count since the last valid sample, saturating at TIMEOUT.
  always_comb begin
    wd_d    = bus.sample_valid ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + WW'(1));
    timeout = (wd_d == WD_MAX);
    fault_d = bus.sample_valid ? 1'b0 : (timeout ? 1'b1 : fault_q);
  end

  // Watchdog and fault registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end

  assign bus.sensor_fault = fault_q;
`else
  assign timeout          = 1'b0;
  assign bus.sensor_fault = 1'b0;
`endif

  level_debouncer #(.DEBOUNCE(DEBOUNCE)) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timeout),
    .valid   (bus.sample_valid),
    .qualify (qualify),
    .restart (restart),
    .hit     (hit)
  );

  // Per-state qualify select and next-state decode; watchdog expiry wins.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    qualify = 1'b0;
    restart = 1'b0;
    case (state_q)
      LVL_NORMAL: begin
        qualify = above_full || below_crit;
        // Switching between full-side and critical-side samples starts a fresh run.
        restart = qualify && (above_full != dir_q);
        if (bus.sample_valid && qualify) dir_d = above_full;
        if (hit) state_d = above_full ? LVL_FULL : LVL_CRITICAL;
      end
      LVL_FULL: begin
        qualify = sample_x < FULL_EXIT;
        if (hit) state_d = LVL_NORMAL;
      end
      LVL_CRITICAL: begin
        qualify = sample_x > CRIT_EXIT;
        if (hit) state_d = LVL_NORMAL;
      end
      default: state_d = LVL_NORMAL;
    endcase
    if (timeout) state_d = LVL_NORMAL;
  end

  // State, direction and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LVL_NORMAL;
      dir_q   <= 1'b0;
      full_q  <= 1'b0;
      crit_q  <= 1'b0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      full_q  <= (state_d == LVL_FULL);
      crit_q  <= (state_d == LVL_CRITICAL);
      if (bus.sample_valid) level_q <= bus.sample_level;
    end
  end

  assign bus.full_tank      = full_q;
  assign bus.critical_level = crit_q;
  assign bus.level_out      = level_q;
endmodule

// File: tb/tb_tank_level_monitor.sv
// Self-checking bench for tank_level_monitor: directed scenarios plus
// randomized samples, all compared against a sample-history reference model.
module tb_tank_level_monitor;
  localparam int WIDTH          = 8;
  localparam int FULL_LEVEL     = 200;
  localparam int CRITICAL_LEVEL = 40;
  localparam int HYST           = 8;
  localparam int DEBOUNCE       = 4;
  localparam int TIMEOUT        = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  tank_level_monitor_if #(.WIDTH(WIDTH)) bus ();

  tank_level_monitor #(
    .WIDTH(WIDTH), .FULL_LEVEL(FULL_LEVEL), .CRITICAL_LEVEL(CRITICAL_LEVEL),
    .HYST(HYST), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int    tests_run = 0;
  int    tests_failed = 0;
  string phase = "init";

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Reference model: state 0=normal 1=full 2=critical. A state changes when the
  // last DEBOUNCE valid samples since the previous change all satisfy its exit rule.
  int m_state = 0;
  int m_level = 0;
  int m_idle  = 0;
  int m_fault = 0;
  int hist[$];

  function automatic bit last_all(input int kind);
    if (hist.size() < DEBOUNCE) return 1'b0;
    for (int k = hist.size() - DEBOUNCE; k < hist.size(); k++) begin
      case (kind)
        0: if (!(hist[k] >= FULL_LEVEL))          return 1'b0;
        1: if (!(hist[k] <= CRITICAL_LEVEL))      return 1'b0;
        2: if (!(hist[k] <  FULL_LEVEL - HYST))   return 1'b0;
        default: if (!(hist[k] > CRITICAL_LEVEL + HYST)) return 1'b0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int lvl);
    int next;
    if (rst) begin
      m_state = 0; m_level = 0; m_idle = 0; m_fault = 0;
      hist.delete();
    end else if (v) begin
      m_idle = 0; m_fault = 0; m_level = lvl;
      hist.push_back(lvl);
      if (hist.size() > DEBOUNCE) void'(hist.pop_front());
      next = m_state;
      case (m_state)
        0: if (last_all(0)) next = 1; else if (last_all(1)) next = 2;
        1: if (last_all(2)) next = 0;
        default: if (last_all(3)) next = 0;
      endcase
      if (next != m_state) begin
        m_state = next;
        hist.delete();
      end
    end else begin
`ifdef SENSOR_TIMEOUT_EN
      if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT) begin
        m_fault = 1; m_state = 0;
        hist.delete();
      end
`endif
    end
  endtask

  // One clock: drive, let the edge pass, advance the model, compare all outputs.
  task automatic tick(input bit rst, input bit v, input int lvl);
    reset            = rst;
    bus.sample_valid = v;
    bus.sample_level = lvl[WIDTH-1:0];
    @(posedge clock);
    #1;
    model_step(rst, v, lvl);
    check("full_tank",      int'(bus.full_tank),      int'(m_state == 1));
    check("critical_level", int'(bus.critical_level), int'(m_state == 2));
    check("level_out",      int'(bus.level_out),      m_level);
    check("sensor_fault",   int'(bus.sensor_fault),   m_fault);
    check("one_hot",        int'(bus.full_tank && bus.critical_level), 0);
  endtask

  task automatic samples(input int lvl, input int n, input int idle_between);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, lvl);
      for (int j = 0; j < idle_between; j++) tick(1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    int lvl;
    int region;
    bit v;
    bus.sample_valid = 1'b0;
    bus.sample_level = '0;

    phase = "reset";
    tick(1'b1, 1'b0, 0);
    tick(1'b1, 1'b1, 123);
    check("rst_level", int'(bus.level_out), 0);

    phase = "t1_normal";
    samples(100, 10, 0);
    check("t1_level", int'(bus.level_out), 100);
    check("t1_full",  int'(bus.full_tank), 0);

    phase = "t2_debounce";
    samples(205, 3, 0);
    samples(150, 1, 0);
    samples(205, 3, 0);
    check("t2_not_yet", int'(bus.full_tank), 0);
    samples(205, 1, 0);
    check("t2_full", int'(bus.full_tank), 1);

    phase = "t3_full_hyst";
    samples(195, 4, 0);
    check("t3_hold", int'(bus.full_tank), 1);
    samples(191, 3, 0);
    check("t3_hold3", int'(bus.full_tank), 1);
    samples(191, 1, 0);
    check("t3_exit", int'(bus.full_tank), 0);

    for (int gap = 0; gap <= 3; gap += 3) begin
      phase = (gap == 0) ? "t4_crit" : "t4_crit_idle";
      samples(30, 4, gap);
      check("t4_enter", int'(bus.critical_level), 1);
      samples(48, 4, gap);
      check("t4_hold", int'(bus.critical_level), 1);
      samples(49, 4, gap);
      check("t4_exit", int'(bus.critical_level), 0);
    end

    phase = "t5_reset_mid";
    samples(210, 3, 0);
    tick(1'b1, 1'b0, 0);
    samples(210, 1, 0);
    check("t5_full", int'(bus.full_tank), 0);
    tick(1'b1, 1'b0, 0);

`ifdef SENSOR_TIMEOUT_EN
    phase = "t6_timeout";
    samples(210, 4, 0);
    check("t6_full", int'(bus.full_tank), 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b0, 1'b0, 0);
    check("t6_no_fault_yet", int'(bus.sensor_fault), 0);
    tick(1'b0, 1'b0, 0);
    check("t6_fault", int'(bus.sensor_fault), 1);
    check("t6_full_drop", int'(bus.full_tank), 0);
    samples(210, 1, 0);
    check("t6_fault_clear", int'(bus.sensor_fault), 0);
    check("t6_full_wait", int'(bus.full_tank), 0);
    samples(210, 3, 0);
    check("t6_full_again", int'(bus.full_tank), 1);
`endif

    phase = "random";
    region = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 8 == 0) region = $urandom_range(0, 4);
      case (region)
        0: lvl = $urandom_range(FULL_LEVEL - 12, 255);
        1: lvl = $urandom_range(0, CRITICAL_LEVEL + 12);
        2: lvl = $urandom_range(FULL_LEVEL - HYST - 2, FULL_LEVEL + 1);
        3: lvl = $urandom_range(CRITICAL_LEVEL - 1, CRITICAL_LEVEL + HYST + 2);
        default: lvl = $urandom_range(0, 255);
      endcase
      v = ($urandom_range(0, 9) < 7);
      tick(($urandom_range(0, 599) == 0), v, lvl);
      if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < int'($urandom_range(10, 20)); j++) tick(1'b0, 1'b0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
